// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// values, instruction classes and datapath mux selects.
package multicycle_pkg;

  localparam logic [3:0] MEM_TIMEOUT_DEFAULT = 4'd15;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_JALR = 6'h09;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  typedef enum logic [3:0] {
    CLS_RTYPE   = 4'd0,
    CLS_SHIFT   = 4'd1,
    CLS_JR      = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_LW      = 4'd4,
    CLS_SW      = 4'd5,
    CLS_BEQ     = 4'd6,
    CLS_J       = 4'd7,
    CLS_JAL     = 4'd8,
    CLS_ITYPE   = 4'd9,
    CLS_ILLEGAL = 4'd10
  } instr_class_e;

  localparam logic [1:0] REGDST_RD = 2'd0;
  localparam logic [1:0] REGDST_RT = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REGA  = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;
  localparam logic [1:0] ALUOP_OPC   = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  function automatic logic is_wait_state(input logic [2:0] s);
    return (s == S_IF) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/multicycle_controller_instr_class_decode.sv
// Combinational instruction classifier: folds OpCode/Funct into the handful of
// classes the sequencer branches on, plus the immediate-extension controls.
module instr_class_decode
  import multicycle_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] class_o,
  output logic       ext_op_o,
  output logic       lu_op_o
);

  // OpCode/Funct to instruction class
  always_comb begin
    class_o = CLS_ILLEGAL;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
          F_XOR, F_NOR, F_SLT, F_SLTU:    class_o = CLS_RTYPE;
          F_SLL, F_SRL, F_SRA:            class_o = CLS_SHIFT;
          F_JR:                           class_o = CLS_JR;
          F_JALR:                         class_o = CLS_JALR;
          default:                        class_o = CLS_ILLEGAL;
        endcase
      end
      OP_LW:  class_o = CLS_LW;
      OP_SW:  class_o = CLS_SW;
      OP_BEQ: class_o = CLS_BEQ;
      OP_J:   class_o = CLS_J;
      OP_JAL: class_o = CLS_JAL;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI:
              class_o = CLS_ITYPE;
      default: class_o = CLS_ILLEGAL;
    endcase
  end

  assign ext_op_o = (op_i != OP_ANDI);
  assign lu_op_o  = (op_i == OP_LUI);

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle MIPS datapath (IF/ID/EX/MEM/WB) with a
// watchdog on the memory ready handshake.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter logic [3:0] MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ExtOp,
  output logic       LuOp,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_error
);

  logic [2:0] state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] cls_s;
  logic       waiting_s, timeout_s;

  logic pc_write_s, pc_write_cond_s, mem_read_s, mem_write_s, ir_write_s;
  logic reg_write_s, done_s, illegal_s, bus_error_s;

  instr_class_decode u_decode (
    .op_i     (OpCode),
    .funct_i  (Funct),
    .class_o  (cls_s),
    .ext_op_o (ExtOp),
    .lu_op_o  (LuOp)
  );

  assign waiting_s = is_wait_state(state_q) && !mem_ready;
  assign timeout_s = waiting_s && (wait_q >= (MEM_TIMEOUT - 4'd1));

  // Output decode and next-state selection
  always_comb begin
    state_d         = state_q;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    IorD            = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    RegDst          = REGDST_RD;
    MemtoReg        = M2R_ALUOUT;
    ALUSrcA         = SRCA_PC;
    ALUSrcB         = SRCB_REGB;
    ALUOp           = ALUOP_ADD;
    PCSource        = PCSRC_ALU;
    done_s          = 1'b0;
    illegal_s       = 1'b0;
    bus_error_s     = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read_s = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_d    = S_ID;
        end else if (timeout_s) begin
          mem_read_s  = 1'b0;
          bus_error_s = 1'b1;
          state_d     = S_IF;
        end else begin
          state_d = S_IF;
        end
      end
      S_ID: begin
        ALUSrcB = SRCB_IMM_SH2;
        case (cls_s)
          CLS_J: begin
            pc_write_s = 1'b1;
            PCSource   = PCSRC_JUMP;
            done_s     = 1'b1;
            state_d    = S_IF;
          end
          CLS_JAL: begin
            pc_write_s  = 1'b1;
            PCSource    = PCSRC_JUMP;
            reg_write_s = 1'b1;
            RegDst      = REGDST_RA;
            MemtoReg    = M2R_PC;
            done_s      = 1'b1;
            state_d     = S_IF;
          end
          CLS_ILLEGAL: begin
            illegal_s = 1'b1;
            state_d   = S_IF;
          end
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (cls_s)
          CLS_RTYPE, CLS_SHIFT: begin
            ALUSrcA = (cls_s == CLS_SHIFT) ? SRCA_SHAMT : SRCA_REGA;
            ALUSrcB = SRCB_REGB;
            ALUOp   = ALUOP_FUNCT;
            state_d = S_WB;
          end
          CLS_JR, CLS_JALR: begin
            pc_write_s = 1'b1;
            PCSource   = PCSRC_REGA;
            if (cls_s == CLS_JALR) begin
              reg_write_s = 1'b1;
              RegDst      = REGDST_RD;
              MemtoReg    = M2R_PC;
            end else begin
              reg_write_s = 1'b0;
            end
            done_s  = 1'b1;
            state_d = S_IF;
          end
          CLS_BEQ: begin
            ALUSrcA         = SRCA_REGA;
            ALUSrcB         = SRCB_REGB;
            ALUOp           = ALUOP_SUB;
            pc_write_cond_s = 1'b1;
            PCSource        = PCSRC_ALUOUT;
            done_s          = 1'b1;
            state_d         = S_IF;
          end
          CLS_LW, CLS_SW: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_ADD;
            state_d = S_MEM;
          end
          CLS_ITYPE: begin
            ALUSrcA = SRCA_REGA;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_OPC;
            state_d = S_WB;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        IorD        = 1'b1;
        mem_read_s  = (cls_s == CLS_LW);
        mem_write_s = (cls_s == CLS_SW);
        if (mem_ready) begin
          if (cls_s == CLS_LW) begin
            state_d = S_WB;
          end else begin
            done_s  = 1'b1;
            state_d = S_IF;
          end
        end else if (timeout_s) begin
          mem_read_s  = 1'b0;
          mem_write_s = 1'b0;
          bus_error_s = 1'b1;
          state_d     = S_IF;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_write_s = 1'b1;
        case (cls_s)
          CLS_LW: begin
            RegDst   = REGDST_RT;
            MemtoReg = M2R_MDR;
          end
          CLS_ITYPE: begin
            RegDst   = REGDST_RT;
            MemtoReg = M2R_ALUOUT;
          end
          default: begin
            RegDst   = REGDST_RD;
            MemtoReg = M2R_ALUOUT;
          end
        endcase
        done_s  = 1'b1;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

  // Watchdog counts consecutive stalled cycles within one state and saturates
  always_comb begin
    if ((state_d != state_q) || timeout_s) begin
      wait_d = 4'd0;
    end else if (waiting_s && (wait_q != 4'hf)) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // State and watchdog registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign PCWrite     = pc_write_s      & ~reset;
  assign PCWriteCond = pc_write_cond_s & ~reset;
  assign MemRead     = mem_read_s      & ~reset;
  assign MemWrite    = mem_write_s     & ~reset;
  assign IRWrite     = ir_write_s      & ~reset;
  assign RegWrite    = reg_write_s     & ~reset;
  assign instr_done  = done_s          & ~reset;
  assign illegal     = illegal_s       & ~reset;
  assign bus_error   = bus_error_s     & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: each step queues the
// expected output vector and checks it against the DUT mid-cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource;
  logic       ExtOp, LuOp, instr_done, illegal, bus_error;

  int tests  = 0;
  int failed = 0;

  logic [23:0] exp_q[$];
  logic [23:0] msk_q[$];
  string       tag_q[$];

  logic [21:0] ifr, ifw, idv, en, all, zero, tmsk;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .ExtOp(ExtOp), .LuOp(LuOp), .instr_done(instr_done),
    .illegal(illegal), .bus_error(bus_error)
  );

  wire [23:0] obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                     RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                     instr_done, illegal, bus_error, ExtOp, LuOp};

  function automatic logic [21:0] ov(input logic pcw, pcwc, iord, mr, mw, irw, rw,
                                     input logic [1:0] rd, m2r, sa, sb, aop, ps,
                                     input logic dn, il, be);
    return {pcw, pcwc, iord, mr, mw, irw, rw, rd, m2r, sa, sb, aop, ps, dn, il, be};
  endfunction

  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic rdy,
                      input logic [21:0] exp, input logic [21:0] msk);
    logic [23:0] e, m;
    string t;
    reset = rst; OpCode = op; Funct = fn; mem_ready = rdy;
    exp_q.push_back({exp, (op != 6'h0c), (op == 6'h0f)});
    msk_q.push_back({msk, 2'b11});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    m = msk_q.pop_front();
    t = tag_q.pop_front();
    tests++;
    assert ((obs & m) === (e & m))
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", t, obs & m, e & m);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    ifr  = ov(1,0,0,1,0,1,0, 2'd0,2'd0,2'd0,2'd1,2'd0,2'd0, 0,0,0);
    ifw  = ov(0,0,0,1,0,0,0, 2'd0,2'd0,2'd0,2'd1,2'd0,2'd0, 0,0,0);
    idv  = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd3,2'd0,2'd0, 0,0,0);
    en   = ov(1,1,0,1,1,1,1, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 1,1,1);
    all  = 22'h3fffff;
    zero = 22'h000000;
    tmsk = all & ~ov(0,0,1,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,0);

    // reset held 3 cycles with ready high: every enable/pulse stays low
    for (int i = 0; i < 3; i++) step("reset", 1'b1, 6'h00, 6'h20, 1'b1, zero, en);

    // add; garbage opcode during IF must be ignored
    step("add_if", 1'b0, 6'h3f, 6'h3f, 1'b1, ifr, all);
    step("add_id", 1'b0, 6'h00, 6'h20, 1'b1, idv, all);
    step("add_ex", 1'b0, 6'h00, 6'h20, 1'b1, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0,2'd2,2'd0, 0,0,0), all);
    step("add_wb", 1'b0, 6'h00, 6'h20, 1'b1, ov(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 1,0,0), all);

    // lw with two stalled MEM cycles: 7 cycles total
    step("lw_if", 1'b0, 6'h23, 6'h00, 1'b1, ifr, all);
    step("lw_id", 1'b0, 6'h23, 6'h00, 1'b1, idv, all);
    step("lw_ex", 1'b0, 6'h23, 6'h00, 1'b1, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2,2'd0,2'd0, 0,0,0), all);
    step("lw_mem_w1", 1'b0, 6'h23, 6'h00, 1'b0, ov(0,0,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,0), all);
    step("lw_mem_w2", 1'b0, 6'h23, 6'h00, 1'b0, ov(0,0,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,0), all);
    step("lw_mem_rdy", 1'b0, 6'h23, 6'h00, 1'b1, ov(0,0,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,0), all);
    step("lw_wb", 1'b0, 6'h23, 6'h00, 1'b1, ov(0,0,0,0,0,0,1, 2'd1,2'd1,2'd0,2'd0,2'd0,2'd0, 1,0,0), all);

    // beq with one stalled fetch cycle
    step("beq_if_wait", 1'b0, 6'h04, 6'h00, 1'b0, ifw, all);
    step("beq_if", 1'b0, 6'h04, 6'h00, 1'b1, ifr, all);
    step("beq_id", 1'b0, 6'h04, 6'h00, 1'b1, idv, all);
    step("beq_ex", 1'b0, 6'h04, 6'h00, 1'b1, ov(0,1,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd0,2'd1,2'd1, 1,0,0), all);

    // jal, j, jr, jalr
    step("jal_if", 1'b0, 6'h03, 6'h00, 1'b1, ifr, all);
    step("jal_id", 1'b0, 6'h03, 6'h00, 1'b1, ov(1,0,0,0,0,0,1, 2'd2,2'd2,2'd0,2'd3,2'd0,2'd2, 1,0,0), all);
    step("j_if", 1'b0, 6'h02, 6'h00, 1'b1, ifr, all);
    step("j_id", 1'b0, 6'h02, 6'h00, 1'b1, ov(1,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd3,2'd0,2'd2, 1,0,0), all);
    step("jr_if", 1'b0, 6'h00, 6'h08, 1'b1, ifr, all);
    step("jr_id", 1'b0, 6'h00, 6'h08, 1'b1, idv, all);
    step("jr_ex", 1'b0, 6'h00, 6'h08, 1'b1, ov(1,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd3, 1,0,0), all);
    step("jalr_if", 1'b0, 6'h00, 6'h09, 1'b1, ifr, all);
    step("jalr_id", 1'b0, 6'h00, 6'h09, 1'b1, idv, all);
    step("jalr_ex", 1'b0, 6'h00, 6'h09, 1'b1, ov(1,0,0,0,0,0,1, 2'd0,2'd2,2'd0,2'd0,2'd0,2'd3, 1,0,0), all);

    // shift and I-type (andi clears ExtOp, lui raises LuOp)
    step("sll_if", 1'b0, 6'h00, 6'h00, 1'b1, ifr, all);
    step("sll_id", 1'b0, 6'h00, 6'h00, 1'b1, idv, all);
    step("sll_ex", 1'b0, 6'h00, 6'h00, 1'b1, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd2,2'd0,2'd2,2'd0, 0,0,0), all);
    step("sll_wb", 1'b0, 6'h00, 6'h00, 1'b1, ov(0,0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 1,0,0), all);
    step("andi_if", 1'b0, 6'h0c, 6'h00, 1'b1, ifr, all);
    step("andi_id", 1'b0, 6'h0c, 6'h00, 1'b1, idv, all);
    step("andi_ex", 1'b0, 6'h0c, 6'h00, 1'b1, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2,2'd3,2'd0, 0,0,0), all);
    step("andi_wb", 1'b0, 6'h0c, 6'h00, 1'b1, ov(0,0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0,2'd0,2'd0, 1,0,0), all);
    step("lui_if", 1'b0, 6'h0f, 6'h00, 1'b1, ifr, all);
    step("lui_id", 1'b0, 6'h0f, 6'h00, 1'b1, idv, all);
    step("lui_ex", 1'b0, 6'h0f, 6'h00, 1'b1, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2,2'd3,2'd0, 0,0,0), all);
    step("lui_wb", 1'b0, 6'h0f, 6'h00, 1'b1, ov(0,0,0,0,0,0,1, 2'd1,2'd0,2'd0,2'd0,2'd0,2'd0, 1,0,0), all);

    // illegal opcode and illegal funct: pulse in ID, then straight back to IF
    step("ill_op_if", 1'b0, 6'h3f, 6'h00, 1'b1, ifr, all);
    step("ill_op_id", 1'b0, 6'h3f, 6'h00, 1'b1, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd3,2'd0,2'd0, 0,1,0), all);
    step("ill_fn_if", 1'b0, 6'h00, 6'h3f, 1'b1, ifr, all);
    step("ill_fn_id", 1'b0, 6'h00, 6'h3f, 1'b1, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd3,2'd0,2'd0, 0,1,0), all);

    // sw with ready stuck low: bus_error on the 15th stalled cycle
    step("swto_if", 1'b0, 6'h2b, 6'h00, 1'b1, ifr, all);
    step("swto_id", 1'b0, 6'h2b, 6'h00, 1'b1, idv, all);
    step("swto_ex", 1'b0, 6'h2b, 6'h00, 1'b1, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2,2'd0,2'd0, 0,0,0), all);
    for (int i = 0; i < 14; i++)
      step("swto_mem_wait", 1'b0, 6'h2b, 6'h00, 1'b0, ov(0,0,1,0,1,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,0), all);
    step("swto_timeout", 1'b0, 6'h2b, 6'h00, 1'b0, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,1), tmsk);

    // sw with ready arriving on the 15th cycle completes normally
    step("sw15_if", 1'b0, 6'h2b, 6'h00, 1'b1, ifr, all);
    step("sw15_id", 1'b0, 6'h2b, 6'h00, 1'b1, idv, all);
    step("sw15_ex", 1'b0, 6'h2b, 6'h00, 1'b1, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2,2'd0,2'd0, 0,0,0), all);
    for (int i = 0; i < 14; i++)
      step("sw15_mem_wait", 1'b0, 6'h2b, 6'h00, 1'b0, ov(0,0,1,0,1,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 0,0,0), all);
    step("sw15_mem_rdy", 1'b0, 6'h2b, 6'h00, 1'b1, ov(0,0,1,0,1,0,0, 2'd0,2'd0,2'd0,2'd0,2'd0,2'd0, 1,0,0), all);

    // reset during sw MEM: no write, fetch restarts next cycle
    step("swrst_if", 1'b0, 6'h2b, 6'h00, 1'b1, ifr, all);
    step("swrst_id", 1'b0, 6'h2b, 6'h00, 1'b1, idv, all);
    step("swrst_ex", 1'b0, 6'h2b, 6'h00, 1'b1, ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd1,2'd2,2'd0,2'd0, 0,0,0), all);
    step("swrst_mem", 1'b1, 6'h2b, 6'h00, 1'b1, zero, en);
    step("swrst_after_if", 1'b0, 6'h2b, 6'h00, 1'b1, ifr, all);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
